// File: rtl/alu_sequencer.sv
// alu_sequencer: FETCH/EXEC/WB instruction sequencer for a 2-bit-opcode ALU.
// It owns the 8-entry register file, the Z/N flags and the program counter.
// It drives the ALU operands from registers and writes the ALU result back.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  input  logic [11:0]       instr_in,
  output logic [PC_W-1:0]   pc_out,
  output logic [1:0]        alu_op_out,
  output logic [DATA_W-1:0] alu_p1_out,
  output logic [DATA_W-1:0] alu_p2_out,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              flag_z_out,
  output logic              flag_n_out,
  output logic              illegal_out,
  input  logic [2:0]        dbg_sel_in,
  output logic [DATA_W-1:0] dbg_data_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [11:0]       instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              z_q, z_d, n_q, n_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [DATA_W-1:0] regs_q [8];
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  // Instruction fields. imm overlaps rs and b3. target overlaps rd, b3 and rs.
  logic [3:0] op;
  logic [2:0] rd, rs;
  logic       b7;
  logic [3:0] imm;
  logic [6:0] target;

  assign op     = instr_q[11:8];
  assign b7     = instr_q[7];
  assign rd     = instr_q[6:4];
  assign rs     = instr_q[2:0];
  assign imm    = instr_q[3:0];
  assign target = instr_q[6:0];

  logic [1:0]        dec_alu_op;
  logic [DATA_W-1:0] dec_p1, dec_p2;
  logic              dec_wr, dec_flags, dec_zero, dec_clr, dec_jump, dec_illegal;

  // Decode the latched instruction into ALU controls and writeback effects.
  always_comb begin
    dec_alu_op  = 2'b00;
    dec_p1      = '0;
    dec_p2      = '0;
    dec_wr      = 1'b0;
    dec_flags   = 1'b0;
    dec_zero    = 1'b0;
    dec_clr     = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    case (op)
      4'h0: begin dec_alu_op = 2'b10; dec_p1 = regs_q[rd]; dec_p2 = regs_q[rs];
                  dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h1: begin dec_alu_op = 2'b11; dec_p1 = regs_q[rd]; dec_p2 = regs_q[rs];
                  dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h2: begin dec_alu_op = 2'b10; dec_p1 = regs_q[rd];
                  dec_p2 = {{(DATA_W-4){1'b0}}, imm};
                  dec_wr = 1'b1; dec_flags = 1'b1; end
      4'h3: begin dec_alu_op = 2'b01; dec_wr = 1'b1; dec_zero = 1'b1; end
      4'h8: begin dec_alu_op = 2'b00; dec_p1 = regs_q[rs]; dec_wr = 1'b1; end
      4'hA: begin dec_alu_op = 2'b11; dec_p1 = regs_q[rd]; dec_p2 = regs_q[rs];
                  dec_flags = 1'b1; end
      4'hB: dec_jump = 1'b1;
      4'hE: dec_clr = 1'b1;
      4'hF: ;
      default: dec_illegal = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  // FSM next state: wait in FETCH for an instruction, then take one cycle each in EXEC and WB.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (instr_valid_in) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // FSM outputs: ready only in FETCH, illegal flagged for the single WB cycle.
  always_comb begin
    instr_ready_out = (state_q == S_FETCH);
    illegal_out     = (state_q == S_WB) && dec_illegal;
  end

  // Datapath next-state: latch the instruction, launch the ALU, then write back.
  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    z_d      = z_q;
    n_d      = n_q;
    alu_op_d = alu_op_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    wr_en    = 1'b0;
    wr_data  = alu_result_in;
    case (state_q)
      S_FETCH: if (instr_valid_in) instr_d = instr_in;
      S_EXEC: begin
        alu_op_d = dec_alu_op;
        p1_d     = dec_p1;
        p2_d     = dec_p2;
      end
      S_WB: begin
        wr_en = dec_wr;
        if (dec_zero) begin
          wr_data = '0;
          z_d     = 1'b1;
          n_d     = 1'b0;
        end else if (dec_flags) begin
          z_d = (alu_result_in == '0);
          n_d = alu_result_in[DATA_W-1];
        end
        if (dec_clr) begin
          z_d = 1'b0;
          n_d = 1'b0;
        end
        // A conditional jump (b7=1) is taken only when Z is set.
        if (dec_jump && (!b7 || z_q)) pc_d = {{(PC_W-7){1'b0}}, target};
        else                          pc_d = pc_q + PC_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      instr_q  <= '0;
      pc_q     <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      alu_op_q <= 2'b00;
      p1_q     <= '0;
      p2_q     <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      z_q      <= z_d;
      n_q      <= n_d;
      alu_op_q <= alu_op_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  // Register file: cleared on reset, written once per instruction in WB.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= wr_data;
    end
  end

  assign pc_out       = pc_q;
  assign alu_op_out   = alu_op_q;
  assign alu_p1_out   = p1_q;
  assign alu_p2_out   = p2_q;
  assign flag_z_out   = z_q;
  assign flag_n_out   = n_q;
  assign dbg_data_out = regs_q[dbg_sel_in];

endmodule
